div_clk_period_meter: RTL

Measures the divided clock produced by the 4-mode clock divider. It samples the divider output in the `clk` domain, counts system-clock cycles between consecutive rising edges (period) and from rising to falling edge (high time), and flags when the measurement is stable or the input has stopped toggling. It sits directly downstream of the divider and lets self-checking benches and on-chip status logic confirm which division ratio is active after a `mode` change.

---
 rtl/div_clk_period_meter_if.sv | 22 ++
 rtl/div_clk_period_meter.sv | 93 +++++++++
 2 files changed

// File: rtl/div_clk_period_meter_if.sv
// Measurement bundle between a divider-side driver and the period meter.
// The driver supplies the divided clock; the meter returns period, high time and status flags.
interface div_clk_period_meter_if #(
   parameter int CNT_W = 16
);
   logic             div_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic             stable;
   logic             timeout;

   modport master (
      output div_in,
      input  period, high_time, meas_valid, stable, timeout
   );

   modport slave (
      input  div_in,
      output period, high_time, meas_valid, stable, timeout
   );
endinterface

// File: rtl/div_clk_period_meter.sv
// Measures period and high time of a clk-synchronous divided clock, with stability and timeout flags.
//   state | meaning
//   IDLE  | waiting for the first rising edge (after reset or timeout)
//   MEAS  | counting clk cycles since the last rising edge
module div_clk_period_meter #(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   div_clk_period_meter_if.slave m
);
   typedef enum logic {IDLE, MEAS} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q;
   logic             d_q;
   logic             first_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] high_time_q;
   logic             meas_valid_q;
   logic             stable_q;
   logic             timeout_q;

   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] cnt_d;

   assign rise  = m.div_in & ~d_q;
   assign fall  = ~m.div_in & d_q;
   assign cnt_d = cnt_q + CNT_ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         d_q          <= 1'b0;
         first_q      <= 1'b0;
         cnt_q        <= '0;
         period_q     <= '0;
         high_time_q  <= '0;
         meas_valid_q <= 1'b0;
         stable_q     <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         d_q          <= m.div_in;
         meas_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rise) begin
                  cnt_q   <= CNT_ONE;
                  first_q <= 1'b1;
                  state_q <= MEAS;
               end
            end
            MEAS: begin
               // A rise on the saturation cycle still completes the measurement.
               if (rise) begin
                  period_q     <= cnt_q;
                  meas_valid_q <= 1'b1;
                  cnt_q        <= CNT_ONE;
                  timeout_q    <= 1'b0;
                  if (first_q) begin
                     stable_q <= 1'b0;
                     first_q  <= 1'b0;
                  end else begin
                     stable_q <= (cnt_q == period_q);
                  end
               end else begin
                  if (fall) begin
                     high_time_q <= cnt_q;
                  end
                  if (cnt_q == CNT_MAX) begin
                     timeout_q <= 1'b1;
                     stable_q  <= 1'b0;
                     state_q   <= IDLE;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m.period     = period_q;
   assign m.high_time  = high_time_q;
   assign m.meas_valid = meas_valid_q;
   assign m.stable     = stable_q;
   assign m.timeout    = timeout_q;
endmodule
